param_rob: RTL and testbench
============================

PARAM_ROB -- requirements
Module: param_rob

Interface
REQ-001 Parameter DEPTH, default 16: usable entries; tags run 1..DEPTH, tag 0 means "no dependency".
REQ-002 Parameter TAG_W, default 5: tag and count width; 2^TAG_W > DEPTH.
REQ-003 Parameters DATA_W=32, ADDR_W=32, REG_W=5: value width, PC width, register index width.
REQ-004 Parameter CMT_W, default 2, legal values 1 or 2: maximum commits per cycle.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 en  in  1  run enable; low freezes state.
REQ-009 alloc_valid_i  in  1; alloc_type_i  in  2 (00 branch, 01 store, 10 load, 11 alu); alloc_rd_i  in  REG_W; alloc_pc_i  in  ADDR_W; alloc_pbr_i  in  1 (predicted taken).
REQ-010 alloc_ready_o  out  1  (count_o != DEPTH) and !flush_o; alloc_tag_o  out  TAG_W  tail tag that the next accepted allocation receives.
REQ-011 wb0_valid_i, wb0_tag_i, wb0_val_i, wb0_br_i, wb0_tgt_i  in  1/TAG_W/DATA_W/1/ADDR_W  CDB result, actual taken, actual target.
REQ-012 wb1_valid_i, wb1_tag_i, wb1_val_i  in  1/TAG_W/DATA_W  LSB result.
REQ-013 qj_tag_i, qk_tag_i  in  TAG_W; qj_rdy_o, qk_rdy_o  out  1; qj_val_o, qk_val_o  out  DATA_W  combinational operand lookup.
REQ-014 cmt_valid_o  out  CMT_W; cmt_rd_o  out  CMT_W*REG_W; cmt_tag_o  out  CMT_W*TAG_W; cmt_val_o  out  CMT_W*DATA_W  register-file commit; slot 0 is the oldest.
REQ-015 lsb_cmt_o  out  1; lsb_cmt_tag_o  out  TAG_W  store commit pulse.
REQ-016 flush_o  out  1; flush_pc_o  out  ADDR_W; flush_taken_o  out  1; flush_tgt_o  out  ADDR_W  mispredict redirect.
REQ-017 count_o  out  TAG_W; full_o  out  1; empty_o  out  1.

Function
REQ-018 Circular FIFO with head and tail tags; the successor of DEPTH is 1; count_o tracks occupancy 0..DEPTH.
REQ-019 Allocation occurs on an edge where en && alloc_valid_i && alloc_ready_o; the entry is written at the tail with ready=0, and the tail advances.
REQ-020 A writeback to an unallocated tag is ignored; if wb0 and wb1 hit the same tag in one cycle, wb0 wins; wb1 never alters branch fields.
REQ-021 Query: tag 0 -> rdy=1, val=0; a same-cycle wb0 hit, else a wb1 hit, else a stored ready entry -> rdy=1 with that value; otherwise rdy=0.
REQ-022 Commit decision uses registered ready bits only; a writeback at edge E is committed no earlier than edge E+1.
REQ-023 Slot 0 commits the head if it is ready; branch/load/alu -> cmt_valid_o[0]; store -> lsb_cmt_o, with cmt_valid_o[0]=0.
REQ-024 Slot 1 (CMT_W=2 only) commits head+1 if slot 0 committed, slot 0 is neither a store nor a mispredict, head+1 is ready, and head+1 is not a store.
REQ-025 All commit, lsb_cmt and flush outputs are registered single-cycle pulses; payload outputs hold their last value.
REQ-026 Mispredict: the head branch commits with pbr != actual taken.
REQ-027 On that mispredict edge: flush_o=1; flush_pc_o=entry PC; flush_taken_o=actual taken; flush_tgt_o = target if taken, else PC+4; the branch's rd/value still commit on slot 0.
REQ-028 On that same mispredict edge, all entries are invalidated, head=tail=1, count=0, and a same-edge allocation is dropped.
REQ-029 While flush_o=1, allocations and writebacks are ignored.
REQ-030 When full, no allocation occurs even if a commit happens on the same edge.
REQ-031 Allocation and commit on the same edge update count by +1 minus the number of commits.
REQ-032 With en=0, all state holds, pulse outputs are driven 0, and the query ports remain functional.
REQ-033 full_o = (count_o == DEPTH); empty_o = (count_o == 0); both are registered.

Reset
REQ-034 On rst: head=tail=1, count=0, all entries not ready, empty_o=1, alloc_tag_o=1, and every other output is 0.
REQ-035 Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

Verification
REQ-036 Reset, then allocate tags 1..16 as alu (DEPTH=16) -> full_o=1, alloc_ready_o=0, alloc_tag_o=1 (wrapped).
REQ-037 Allocate alu tags 1 and 2, wb0 both with 0x11 and 0x22 at edge E -> at edge E+1 cmt_valid_o=2'b11 with vals 0x11/0x22 and count_o=0.
REQ-038 Tag 1 store, tag 2 alu, both ready -> lsb_cmt_o=1 with tag 1 and cmt_valid_o=0; tag 2 commits on the next cycle.
REQ-039 Branch pc=0x100 with pbr=0, wb0_br_i=1, tgt=0x200, younger entries present -> flush_o=1, flush_tgt_o=0x200, count_o=0; next alloc_tag_o=1.
REQ-040 wb0 and wb1 both target tag 3 in one cycle with qj_tag_i=3 -> qj_rdy_o=1 with the wb0 value; the stored value is the wb0 value.
REQ-041 Assert rst asynchronously between edges while full -> outputs return to the reset values before the next clock edge.

Source files
------------

// File: rtl/param_rob_if.sv
// param_rob_if: allocate, writeback, operand lookup, commit and
// redirect bundle between the core datapath and the reorder buffer.
interface param_rob_if #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5,
  parameter int CMT_W  = 2
);
  logic                    alloc_valid_i;
  logic [1:0]              alloc_type_i;
  logic [REG_W-1:0]        alloc_rd_i;
  logic [ADDR_W-1:0]       alloc_pc_i;
  logic                    alloc_pbr_i;
  logic                    alloc_ready_o;
  logic [TAG_W-1:0]        alloc_tag_o;

  logic                    wb0_valid_i;
  logic [TAG_W-1:0]        wb0_tag_i;
  logic [DATA_W-1:0]       wb0_val_i;
  logic                    wb0_br_i;
  logic [ADDR_W-1:0]       wb0_tgt_i;
  logic                    wb1_valid_i;
  logic [TAG_W-1:0]        wb1_tag_i;
  logic [DATA_W-1:0]       wb1_val_i;

  logic [TAG_W-1:0]        qj_tag_i;
  logic [TAG_W-1:0]        qk_tag_i;
  logic                    qj_rdy_o;
  logic                    qk_rdy_o;
  logic [DATA_W-1:0]       qj_val_o;
  logic [DATA_W-1:0]       qk_val_o;

  logic [CMT_W-1:0]        cmt_valid_o;
  logic [CMT_W*REG_W-1:0]  cmt_rd_o;
  logic [CMT_W*TAG_W-1:0]  cmt_tag_o;
  logic [CMT_W*DATA_W-1:0] cmt_val_o;
  logic                    lsb_cmt_o;
  logic [TAG_W-1:0]        lsb_cmt_tag_o;

  logic                    flush_o;
  logic [ADDR_W-1:0]       flush_pc_o;
  logic                    flush_taken_o;
  logic [ADDR_W-1:0]       flush_tgt_o;

  logic [TAG_W-1:0]        count_o;
  logic                    full_o;
  logic                    empty_o;

  modport master (
    output alloc_valid_i, alloc_type_i, alloc_rd_i,
    output alloc_pc_i, alloc_pbr_i,
    input  alloc_ready_o, alloc_tag_o,
    output wb0_valid_i, wb0_tag_i, wb0_val_i,
    output wb0_br_i, wb0_tgt_i,
    output wb1_valid_i, wb1_tag_i, wb1_val_i,
    output qj_tag_i, qk_tag_i,
    input  qj_rdy_o, qk_rdy_o, qj_val_o, qk_val_o,
    input  cmt_valid_o, cmt_rd_o, cmt_tag_o, cmt_val_o,
    input  lsb_cmt_o, lsb_cmt_tag_o,
    input  flush_o, flush_pc_o, flush_taken_o, flush_tgt_o,
    input  count_o, full_o, empty_o
  );

  modport slave (
    input  alloc_valid_i, alloc_type_i, alloc_rd_i,
    input  alloc_pc_i, alloc_pbr_i,
    output alloc_ready_o, alloc_tag_o,
    input  wb0_valid_i, wb0_tag_i, wb0_val_i,
    input  wb0_br_i, wb0_tgt_i,
    input  wb1_valid_i, wb1_tag_i, wb1_val_i,
    input  qj_tag_i, qk_tag_i,
    output qj_rdy_o, qk_rdy_o, qj_val_o, qk_val_o,
    output cmt_valid_o, cmt_rd_o, cmt_tag_o, cmt_val_o,
    output lsb_cmt_o, lsb_cmt_tag_o,
    output flush_o, flush_pc_o, flush_taken_o, flush_tgt_o,
    output count_o, full_o, empty_o
  );
endinterface

// File: rtl/param_rob.sv
// param_rob: circular reorder buffer with tags 1..DEPTH, dual
// writeback, operand lookup, in-order commit and mispredict flush.
module param_rob #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5,
  parameter int CMT_W  = 2
) (
  input logic       clk,
  input logic       rst,
  input logic       en,
  param_rob_if.slave io
);
  localparam int N = 2 ** TAG_W;
  localparam logic [TAG_W-1:0] TDEP = TAG_W'(DEPTH);
  localparam logic [TAG_W-1:0] TONE = TAG_W'(1);
  localparam logic [TAG_W-1:0] TTWO = TAG_W'(2);
  localparam logic [1:0] T_BR = 2'b00;
  localparam logic [1:0] T_ST = 2'b01;

  logic [N-1:0]      busy;
  logic [N-1:0]      rdy;
  logic [N-1:0]      e_pbr;
  logic [N-1:0]      e_br;
  logic [1:0]        e_type [N];
  logic [REG_W-1:0]  e_rd   [N];
  logic [ADDR_W-1:0] e_pc   [N];
  logic [DATA_W-1:0] e_val  [N];
  logic [ADDR_W-1:0] e_tgt  [N];

  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [TAG_W-1:0]  count;
  logic              full_q;
  logic              empty_q;
  logic              flush_q;
  logic              taken_q;
  logic [ADDR_W-1:0] fpc_q;
  logic [ADDR_W-1:0] ftgt_q;
  logic              lsb_q;
  logic [TAG_W-1:0]  lsb_tag_q;
  logic [1:0]          cv_q;
  logic [2*REG_W-1:0]  crd_q;
  logic [2*TAG_W-1:0]  ctag_q;
  logic [2*DATA_W-1:0] cval_q;

  function automatic logic [TAG_W-1:0] nxt(
    input logic [TAG_W-1:0] t
  );
    return (t == TDEP) ? TONE : t + TONE;
  endfunction

  logic [TAG_W-1:0] h1;
  logic             c0;
  logic             c0_st;
  logic             mis;
  logic             mis1;
  logic             c1;
  logic             cm0;
  logic             cm1;
  logic             mis_e;
  logic             alloc_ready;
  logic             acc;
  logic             wb0_ok;
  logic             wb1_ok;
  logic [TAG_W-1:0] ncmt;
  logic [TAG_W-1:0] cnt_nx;

  assign h1    = nxt(head);
  assign c0    = busy[head] && rdy[head];
  assign c0_st = (e_type[head] == T_ST);
  assign mis   = c0 && (e_type[head] == T_BR)
              && (e_pbr[head] != e_br[head]);
  // a mispredicting branch must reach the head to redirect
  assign mis1  = (e_type[h1] == T_BR) && (e_pbr[h1] != e_br[h1]);
  assign c1    = (CMT_W == 2) && c0 && !c0_st && !mis
              && (count >= TTWO) && busy[h1] && rdy[h1]
              && (e_type[h1] != T_ST) && !mis1;
  assign cm0   = en && c0;
  assign cm1   = en && c1;
  assign mis_e = en && mis;

  assign alloc_ready = !rst && (count != TDEP) && !flush_q;
  assign acc = en && io.alloc_valid_i && alloc_ready && !mis_e;

  assign wb0_ok = en && !flush_q && io.wb0_valid_i
               && busy[io.wb0_tag_i];
  assign wb1_ok = en && !flush_q && io.wb1_valid_i
               && busy[io.wb1_tag_i]
               && !(wb0_ok && io.wb0_tag_i == io.wb1_tag_i);

  assign ncmt   = TAG_W'(cm0) + TAG_W'(cm1);
  assign cnt_nx = count + TAG_W'(acc) - ncmt;

  function automatic logic [DATA_W:0] look(
    input logic [TAG_W-1:0] t
  );
    if (t == '0)
      return {1'b1, {DATA_W{1'b0}}};
    if (wb0_ok && io.wb0_tag_i == t)
      return {1'b1, io.wb0_val_i};
    if (wb1_ok && io.wb1_tag_i == t)
      return {1'b1, io.wb1_val_i};
    if (busy[t] && rdy[t])
      return {1'b1, e_val[t]};
    return '0;
  endfunction

  // Operand lookup with same-cycle writeback forwarding.
  always_comb begin
    {io.qj_rdy_o, io.qj_val_o} = look(io.qj_tag_i);
    {io.qk_rdy_o, io.qk_val_o} = look(io.qk_tag_i);
  end

  // Pointers, occupancy, ready bits and registered pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= '0;
      rdy       <= '0;
      head      <= TONE;
      tail      <= TONE;
      count     <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      flush_q   <= 1'b0;
      taken_q   <= 1'b0;
      fpc_q     <= '0;
      ftgt_q    <= '0;
      lsb_q     <= 1'b0;
      lsb_tag_q <= '0;
      cv_q      <= '0;
      crd_q     <= '0;
      ctag_q    <= '0;
      cval_q    <= '0;
    end else begin
      cv_q    <= '0;
      lsb_q   <= 1'b0;
      flush_q <= 1'b0;
      if (en) begin
        if (wb0_ok) rdy[io.wb0_tag_i] <= 1'b1;
        if (wb1_ok) rdy[io.wb1_tag_i] <= 1'b1;
        if (cm0) begin
          busy[head] <= 1'b0;
          rdy[head]  <= 1'b0;
          if (c0_st) begin
            lsb_q     <= 1'b1;
            lsb_tag_q <= head;
          end else begin
            cv_q[0]              <= 1'b1;
            crd_q[REG_W-1:0]     <= e_rd[head];
            ctag_q[TAG_W-1:0]    <= head;
            cval_q[DATA_W-1:0]   <= e_val[head];
          end
        end
        if (cm1) begin
          busy[h1] <= 1'b0;
          rdy[h1]  <= 1'b0;
          cv_q[1]                   <= 1'b1;
          crd_q[2*REG_W-1:REG_W]    <= e_rd[h1];
          ctag_q[2*TAG_W-1:TAG_W]   <= h1;
          cval_q[2*DATA_W-1:DATA_W] <= e_val[h1];
        end
        if (acc) begin
          busy[tail] <= 1'b1;
          rdy[tail]  <= 1'b0;
          tail       <= nxt(tail);
        end
        head    <= cm1 ? nxt(h1) : (cm0 ? h1 : head);
        count   <= cnt_nx;
        full_q  <= (cnt_nx == TDEP);
        empty_q <= (cnt_nx == '0);
        if (mis_e) begin
          flush_q <= 1'b1;
          fpc_q   <= e_pc[head];
          taken_q <= e_br[head];
          ftgt_q  <= e_br[head] ? e_tgt[head]
                                : e_pc[head] + ADDR_W'(4);
          busy    <= '0;
          rdy     <= '0;
          head    <= TONE;
          tail    <= TONE;
          count   <= '0;
          full_q  <= 1'b0;
          empty_q <= 1'b1;
        end
      end
    end
  end

  // Entry payload; written on allocation and accepted writebacks.
  always_ff @(posedge clk) begin
    if (acc) begin
      e_type[tail] <= io.alloc_type_i;
      e_rd[tail]   <= io.alloc_rd_i;
      e_pc[tail]   <= io.alloc_pc_i;
      e_pbr[tail]  <= io.alloc_pbr_i;
      e_br[tail]   <= 1'b0;
      e_val[tail]  <= '0;
      e_tgt[tail]  <= '0;
    end
    if (wb0_ok) begin
      e_val[io.wb0_tag_i] <= io.wb0_val_i;
      e_br[io.wb0_tag_i]  <= io.wb0_br_i;
      e_tgt[io.wb0_tag_i] <= io.wb0_tgt_i;
    end
    if (wb1_ok) begin
      e_val[io.wb1_tag_i] <= io.wb1_val_i;
    end
  end

  assign io.alloc_ready_o = alloc_ready;
  assign io.alloc_tag_o   = tail;
  assign io.cmt_valid_o   = cv_q[CMT_W-1:0];
  assign io.cmt_rd_o      = crd_q[CMT_W*REG_W-1:0];
  assign io.cmt_tag_o     = ctag_q[CMT_W*TAG_W-1:0];
  assign io.cmt_val_o     = cval_q[CMT_W*DATA_W-1:0];
  assign io.lsb_cmt_o     = lsb_q;
  assign io.lsb_cmt_tag_o = lsb_tag_q;
  assign io.flush_o       = flush_q;
  assign io.flush_pc_o    = fpc_q;
  assign io.flush_taken_o = taken_q;
  assign io.flush_tgt_o   = ftgt_q;
  assign io.count_o       = count;
  assign io.full_o        = full_q;
  assign io.empty_o       = empty_q;
endmodule

// File: tb/tb_param_rob.sv
// tb_param_rob: directed vectors for param_rob with a lookup table
// and hand-written sequences for commit, flush and reset cases.
module tb_param_rob;
  localparam int DEPTH  = 16;
  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int REG_W  = 5;
  localparam int CMT_W  = 2;

  logic clk = 1'b0;
  logic rst;
  logic en;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_rob_if #(
    .TAG_W(TAG_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .REG_W(REG_W), .CMT_W(CMT_W)
  ) bus ();

  param_rob #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W),
    .ADDR_W(ADDR_W), .REG_W(REG_W), .CMT_W(CMT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .io(bus)
  );

  typedef struct {
    int w0v; int w0t; int w0d;
    int w1v; int w1t; int w1d;
    int qj;  int qk;
    int ejr; int ejv;
    int ekr; int ekv;
  } qv_t;

  qv_t tab [9];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_valid_i = 1'b0;
    bus.alloc_type_i  = 2'b11;
    bus.alloc_rd_i    = '0;
    bus.alloc_pc_i    = '0;
    bus.alloc_pbr_i   = 1'b0;
    bus.wb0_valid_i   = 1'b0;
    bus.wb0_tag_i     = '0;
    bus.wb0_val_i     = '0;
    bus.wb0_br_i      = 1'b0;
    bus.wb0_tgt_i     = '0;
    bus.wb1_valid_i   = 1'b0;
    bus.wb1_tag_i     = '0;
    bus.wb1_val_i     = '0;
    bus.qj_tag_i      = '0;
    bus.qk_tag_i      = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [1:0] ty,
                       input logic [4:0] rd,
                       input logic [31:0] pc,
                       input logic pbr);
    bus.alloc_valid_i = 1'b1;
    bus.alloc_type_i  = ty;
    bus.alloc_rd_i    = rd;
    bus.alloc_pc_i    = pc;
    bus.alloc_pbr_i   = pbr;
    step();
    bus.alloc_valid_i = 1'b0;
  endtask

  task automatic wb0(input logic [4:0] t, input logic [31:0] d,
                     input logic br, input logic [31:0] tgt);
    bus.wb0_valid_i = 1'b1;
    bus.wb0_tag_i   = t;
    bus.wb0_val_i   = d;
    bus.wb0_br_i    = br;
    bus.wb0_tgt_i   = tgt;
  endtask

  task automatic wb1(input logic [4:0] t, input logic [31:0] d);
    bus.wb1_valid_i = 1'b1;
    bus.wb1_tag_i   = t;
    bus.wb1_val_i   = d;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tab[0] = '{0,0,0,    0,0,0,    0,2, 1,0,    0,0};
    tab[1] = '{1,2,'h22, 0,0,0,    2,3, 1,'h22, 0,0};
    tab[2] = '{0,0,0,    0,0,0,    2,6, 1,'h22, 0,0};
    tab[3] = '{0,0,0,    1,4,'h44, 4,2, 1,'h44, 1,'h22};
    tab[4] = '{1,3,'h33, 1,3,'h99, 3,4, 1,'h33, 1,'h44};
    tab[5] = '{0,0,0,    0,0,0,    3,4, 1,'h33, 1,'h44};
    tab[6] = '{1,9,'h55, 0,0,0,    9,5, 0,0,    0,0};
    tab[7] = '{1,2,'h77, 1,5,'h55, 5,2, 1,'h55, 1,'h77};
    tab[8] = '{0,0,0,    0,0,0,    5,2, 1,'h55, 1,'h77};

    rst = 1'b1;
    en  = 1'b1;
    idle();
    #3;
    chk("rst_count", 64'(bus.count_o), 64'd0);
    chk("rst_empty", 64'(bus.empty_o), 64'd1);
    chk("rst_full", 64'(bus.full_o), 64'd0);
    chk("rst_tag", 64'(bus.alloc_tag_o), 64'd1);
    chk("rst_cmt", 64'(bus.cmt_valid_o), 64'd0);
    chk("rst_flush", 64'(bus.flush_o), 64'd0);
    chk("rst_lsb", 64'(bus.lsb_cmt_o), 64'd0);
    chk("rst_ready", 64'(bus.alloc_ready_o), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(bus.alloc_ready_o), 64'd1);

    // fill all entries
    bus.alloc_valid_i = 1'b1;
    bus.alloc_type_i  = 2'b11;
    for (int i = 0; i < DEPTH; i++) begin
      bus.alloc_rd_i = 5'(i);
      step();
    end
    bus.alloc_valid_i = 1'b0;
    chk("fill_count", 64'(bus.count_o), 64'd16);
    chk("fill_full", 64'(bus.full_o), 64'd1);
    chk("fill_ready", 64'(bus.alloc_ready_o), 64'd0);
    chk("fill_tag", 64'(bus.alloc_tag_o), 64'd1);
    chk("fill_empty", 64'(bus.empty_o), 64'd0);

    // full: commit and alloc attempt on the same edge
    wb0(5'd1, 32'h5, 1'b0, 32'h0);
    step();
    idle();
    bus.alloc_valid_i = 1'b1;
    step();
    chk("fullc_cmt", 64'(bus.cmt_valid_o), 64'd1);
    chk("fullc_ctag", 64'(bus.cmt_tag_o[4:0]), 64'd1);
    chk("fullc_count", 64'(bus.count_o), 64'd15);
    chk("fullc_tag", 64'(bus.alloc_tag_o), 64'd1);
    chk("fullc_full", 64'(bus.full_o), 64'd0);
    step();
    bus.alloc_valid_i = 1'b0;
    chk("refill_count", 64'(bus.count_o), 64'd16);
    chk("refill_full", 64'(bus.full_o), 64'd1);
    chk("refill_tag", 64'(bus.alloc_tag_o), 64'd2);

    // asynchronous reset between edges while full
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", 64'(bus.count_o), 64'd0);
    chk("arst_full", 64'(bus.full_o), 64'd0);
    chk("arst_empty", 64'(bus.empty_o), 64'd1);
    chk("arst_tag", 64'(bus.alloc_tag_o), 64'd1);
    #1;
    rst = 1'b0;
    step();

    // dual commit, then alloc and commit on one edge
    alloc(2'b11, 5'd3, 32'h0, 1'b0);
    alloc(2'b11, 5'd4, 32'h4, 1'b0);
    wb0(5'd1, 32'h11, 1'b0, 32'h0);
    wb1(5'd2, 32'h22);
    step();
    chk("dual_e", 64'(bus.cmt_valid_o), 64'd0);
    idle();
    bus.alloc_valid_i = 1'b1;
    bus.alloc_rd_i    = 5'd9;
    step();
    bus.alloc_valid_i = 1'b0;
    chk("dual_cmt", 64'(bus.cmt_valid_o), 64'd3);
    chk("dual_val", 64'(bus.cmt_val_o), 64'h00000022_00000011);
    chk("dual_rd", 64'(bus.cmt_rd_o), 64'd131);
    chk("dual_ctag", 64'(bus.cmt_tag_o), 64'd65);
    chk("dual_count", 64'(bus.count_o), 64'd1);
    chk("dual_tag", 64'(bus.alloc_tag_o), 64'd4);
    step();
    chk("dual_pulse", 64'(bus.cmt_valid_o), 64'd0);
    chk("dual_hold", 64'(bus.cmt_val_o), 64'h00000022_00000011);

    // operand lookup table
    do_reset();
    for (int i = 1; i <= 5; i++)
      alloc(2'b11, 5'(i), 32'(i * 4), 1'b0);
    for (int i = 0; i < 9; i++) begin
      bus.wb0_valid_i = tab[i].w0v[0];
      bus.wb0_tag_i   = 5'(tab[i].w0t);
      bus.wb0_val_i   = 32'(tab[i].w0d);
      bus.wb1_valid_i = tab[i].w1v[0];
      bus.wb1_tag_i   = 5'(tab[i].w1t);
      bus.wb1_val_i   = 32'(tab[i].w1d);
      bus.qj_tag_i    = 5'(tab[i].qj);
      bus.qk_tag_i    = 5'(tab[i].qk);
      #1;
      chk($sformatf("q%0d_jr", i), 64'(bus.qj_rdy_o),
          64'(tab[i].ejr));
      chk($sformatf("q%0d_kr", i), 64'(bus.qk_rdy_o),
          64'(tab[i].ekr));
      if (tab[i].ejr != 0)
        chk($sformatf("q%0d_jv", i), 64'(bus.qj_val_o),
            64'(tab[i].ejv));
      if (tab[i].ekr != 0)
        chk($sformatf("q%0d_kv", i), 64'(bus.qk_val_o),
            64'(tab[i].ekv));
      step();
      idle();
      chk($sformatf("q%0d_cnt", i), 64'(bus.count_o), 64'd5);
    end

    // en low: state holds, lookup still works
    en = 1'b0;
    wb0(5'd1, 32'h10, 1'b0, 32'h0);
    bus.qj_tag_i = 5'd2;
    #1;
    chk("en0_q", 64'(bus.qj_val_o), 64'h77);
    step();
    chk("en0_count", 64'(bus.count_o), 64'd5);
    chk("en0_cmt", 64'(bus.cmt_valid_o), 64'd0);
    idle();
    bus.qj_tag_i = 5'd1;
    #1;
    chk("en0_nowb", 64'(bus.qj_rdy_o), 64'd0);
    en = 1'b1;
    wb0(5'd1, 32'h10, 1'b0, 32'h0);
    step();
    idle();
    step();
    chk("drain1_cmt", 64'(bus.cmt_valid_o), 64'd3);
    chk("drain1_val", 64'(bus.cmt_val_o), 64'h00000077_00000010);
    chk("drain1_cnt", 64'(bus.count_o), 64'd3);
    step();
    chk("drain2_cmt", 64'(bus.cmt_valid_o), 64'd3);
    chk("drain2_ctag", 64'(bus.cmt_tag_o), 64'd131);
    chk("drain2_cnt", 64'(bus.count_o), 64'd1);
    step();
    chk("drain3_cmt", 64'(bus.cmt_valid_o), 64'd1);
    chk("drain3_cnt", 64'(bus.count_o), 64'd0);
    chk("drain3_empty", 64'(bus.empty_o), 64'd1);

    // store at head blocks slot 1
    do_reset();
    alloc(2'b01, 5'd0, 32'h0, 1'b0);
    alloc(2'b11, 5'd7, 32'h4, 1'b0);
    wb1(5'd1, 32'h0);
    wb0(5'd2, 32'hBB, 1'b0, 32'h0);
    step();
    idle();
    step();
    chk("st_lsb", 64'(bus.lsb_cmt_o), 64'd1);
    chk("st_lsbtag", 64'(bus.lsb_cmt_tag_o), 64'd1);
    chk("st_cmt", 64'(bus.cmt_valid_o), 64'd0);
    chk("st_count", 64'(bus.count_o), 64'd1);
    step();
    chk("st2_lsb", 64'(bus.lsb_cmt_o), 64'd0);
    chk("st2_cmt", 64'(bus.cmt_valid_o), 64'd1);
    chk("st2_ctag", 64'(bus.cmt_tag_o[4:0]), 64'd2);
    chk("st2_val", 64'(bus.cmt_val_o[31:0]), 64'hBB);
    chk("st2_rd", 64'(bus.cmt_rd_o[4:0]), 64'd7);
    chk("st2_count", 64'(bus.count_o), 64'd0);

    // taken mispredict with younger entries
    do_reset();
    alloc(2'b00, 5'd1, 32'h100, 1'b0);
    alloc(2'b11, 5'd2, 32'h104, 1'b0);
    alloc(2'b11, 5'd3, 32'h108, 1'b0);
    wb0(5'd1, 32'hAA, 1'b1, 32'h200);
    wb1(5'd2, 32'h22);
    step();
    idle();
    bus.alloc_valid_i = 1'b1;
    step();
    chk("mp_flush", 64'(bus.flush_o), 64'd1);
    chk("mp_pc", 64'(bus.flush_pc_o), 64'h100);
    chk("mp_taken", 64'(bus.flush_taken_o), 64'd1);
    chk("mp_tgt", 64'(bus.flush_tgt_o), 64'h200);
    chk("mp_cmt", 64'(bus.cmt_valid_o), 64'd1);
    chk("mp_val", 64'(bus.cmt_val_o[31:0]), 64'hAA);
    chk("mp_count", 64'(bus.count_o), 64'd0);
    chk("mp_tag", 64'(bus.alloc_tag_o), 64'd1);
    chk("mp_ready", 64'(bus.alloc_ready_o), 64'd0);
    step();
    chk("mp2_flush", 64'(bus.flush_o), 64'd0);
    chk("mp2_count", 64'(bus.count_o), 64'd0);
    chk("mp2_ready", 64'(bus.alloc_ready_o), 64'd1);
    step();
    bus.alloc_valid_i = 1'b0;
    chk("mp3_count", 64'(bus.count_o), 64'd1);
    chk("mp3_tag", 64'(bus.alloc_tag_o), 64'd2);

    // not-taken mispredict, then a correct prediction
    do_reset();
    alloc(2'b00, 5'd1, 32'h300, 1'b1);
    wb0(5'd1, 32'h0, 1'b0, 32'h500);
    step();
    idle();
    step();
    chk("nt_flush", 64'(bus.flush_o), 64'd1);
    chk("nt_taken", 64'(bus.flush_taken_o), 64'd0);
    chk("nt_tgt", 64'(bus.flush_tgt_o), 64'h304);
    chk("nt_pc", 64'(bus.flush_pc_o), 64'h300);
    step();
    alloc(2'b00, 5'd2, 32'h400, 1'b1);
    wb0(5'd1, 32'h0, 1'b1, 32'h500);
    step();
    idle();
    step();
    chk("ok_flush", 64'(bus.flush_o), 64'd0);
    chk("ok_cmt", 64'(bus.cmt_valid_o), 64'd1);
    chk("ok_count", 64'(bus.count_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
